ps2_host_tx: RTL

//  PS/2 host-to-device transmitter, the counterpart of the PS/2 receive path.

---
 rtl/ps2_host_tx_if.sv | 24 ++
 rtl/ps2_host_tx.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx_if.sv
// Host-side PS/2 transmit bundle: byte request handshake, status pulses and open-collector pad controls.
// master = command source / pad model, slave = transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       err;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;

  modport master (
    output tx_data, tx_valid, ps2_clk_in, ps2_data_in,
    input  tx_ready, busy, done, err, ps2_clk_oe, ps2_data_oe
  );

  modport slave (
    input  tx_data, tx_valid, ps2_clk_in, ps2_data_in,
    output tx_ready, busy, done, err, ps2_clk_oe, ps2_data_oe
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, 8 data + odd parity + stop, ACK check.
// Accepts one byte in IDLE only; done/err pulse once per frame, tx_ready returns the cycle after.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input logic          clk,
  input logic          rst_n,
  ps2_host_tx_if.slave io_bus
);
  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES + 1) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQ, RELEASE, SEND, WAIT_ACK, WAIT_IDLE
  } state_t;

  state_t            r_state;
  logic              r_clk_s1, r_clk_s2, r_clk_prev;
  logic              r_dat_s1, r_dat_s2;
  logic [7:0]        r_byte;
  logic              r_par;
  logic [INH_W-1:0]  r_inh_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic [3:0]        r_edge_cnt;
  logic              r_tx_ready, r_busy, r_done, r_err;
  logic              r_clk_oe, r_data_oe;

  logic              w_fall;
  logic              w_timeout;
  logic [3:0]        w_edge_nxt;
  logic [2:0]        w_bit_idx;

  // Pads idle high, so the synchronizers reset to 1 to avoid a phantom falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= io_bus.ps2_clk_in;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= io_bus.ps2_data_in;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_fall     = r_clk_prev & ~r_clk_s2;
  assign w_timeout  = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign w_edge_nxt = (r_edge_cnt == 4'hF) ? 4'hF : r_edge_cnt + 4'd1;
  assign w_bit_idx  = 3'(w_edge_nxt - 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_byte     <= 8'h00;
      r_par      <= 1'b0;
      r_inh_cnt  <= '0;
      r_to_cnt   <= '0;
      r_edge_cnt <= 4'd0;
      r_tx_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_clk_oe   <= 1'b0;
      r_data_oe  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          // tx_ready is re-armed here rather than on entry, so it trails done/err by a cycle.
          r_clk_oe   <= 1'b0;
          r_data_oe  <= 1'b0;
          r_busy     <= 1'b0;
          r_tx_ready <= 1'b1;
          if (io_bus.tx_valid && r_tx_ready) begin
            r_byte     <= io_bus.tx_data;
            r_par      <= ~^io_bus.tx_data;
            r_inh_cnt  <= '0;
            r_tx_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_clk_oe   <= 1'b1;
            r_state    <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
            r_data_oe <= 1'b1;
            r_state   <= REQ;
          end else begin
            r_inh_cnt <= r_inh_cnt + INH_W'(1);
          end
        end
        REQ: begin
          r_clk_oe <= 1'b0;
          r_state  <= RELEASE;
        end
        RELEASE: begin
          r_edge_cnt <= 4'd0;
          r_to_cnt   <= '0;
          r_state    <= SEND;
        end
        SEND, WAIT_ACK, WAIT_IDLE: begin
          if (w_timeout) begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_err     <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
            if (r_state == SEND) begin
              if (w_fall) begin
                r_edge_cnt <= w_edge_nxt;
                if (w_edge_nxt <= 4'd8) begin
                  r_data_oe <= ~r_byte[w_bit_idx];
                end else if (w_edge_nxt == 4'd9) begin
                  r_data_oe <= ~r_par;
                end else begin
                  r_data_oe <= 1'b0;
                  r_state   <= WAIT_ACK;
                end
              end
            end else if (r_state == WAIT_ACK) begin
              if (w_fall) begin
                if (!r_dat_s2) begin
                  r_state <= WAIT_IDLE;
                end else begin
                  r_err   <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
                end
              end
            end else if (r_clk_s2 && r_dat_s2) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_bus.tx_ready    = r_tx_ready;
  assign io_bus.busy        = r_busy;
  assign io_bus.done        = r_done;
  assign io_bus.err         = r_err;
  assign io_bus.ps2_clk_oe  = r_clk_oe;
  assign io_bus.ps2_data_oe = r_data_oe;
endmodule
